// File: rtl/fifo_stream_checker.sv
// Read-side stream checker: pops the dual-clock FIFO in the read_clk domain and
// verifies the arithmetic transmitter pattern word n = n*STEP mod 2^W.
module fifo_stream_checker #(
  parameter int unsigned W       = 16,
  parameter int unsigned STEP    = 5,
  parameter int unsigned COUNT   = 256,
  parameter int unsigned CW      = 16,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic          read_clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          r_empty,
  input  logic [W-1:0]  data_in,
  output logic          rd_en,
  output logic [CW-1:0] rx_count,
  output logic [CW-1:0] err_count,
  output logic          first_err_valid,
  output logic [CW-1:0] first_err_idx,
  output logic [W-1:0]  first_err_data,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          timeout
);

  localparam int unsigned    SW         = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  COUNT_C    = CW'(COUNT);
  localparam logic [CW-1:0]  LAST_IDX   = CW'(COUNT - 1);
  localparam logic [W-1:0]   STEP_C     = W'(STEP);
  localparam logic [SW-1:0]  STALL_LAST = SW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE, TMO} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  expected;
  logic [SW-1:0] stall_cnt;
  logic          start;
  logic          last_pop;
  logic          stall_hit;
  logic          mismatch;

  // Pop is purely combinational so it follows r_empty in the same cycle.
  assign rd_en     = reset && (state == RUN) && !r_empty && (rx_count < COUNT_C);
  assign start     = (state == IDLE) && enable;
  assign last_pop  = rd_en && (rx_count == LAST_IDX);
  assign stall_hit = (state == RUN) && r_empty && (stall_cnt == STALL_LAST);
  assign mismatch  = (data_in != expected);

  always_ff @(posedge read_clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Dropping enable outranks both completion and timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (enable) state_nxt = RUN;
      RUN: begin
        if (!enable)        state_nxt = IDLE;
        else if (last_pop)  state_nxt = DONE;
        else if (stall_hit) state_nxt = TMO;
      end
      DONE, TMO: if (!enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge read_clk) begin
    if (!reset || start) begin
      rx_count        <= '0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
      first_err_data  <= '0;
      expected        <= '0;
      stall_cnt       <= '0;
    end else if (state == RUN) begin
      if (rd_en) begin
        rx_count  <= rx_count + 1'b1;
        expected  <= expected + STEP_C;
        stall_cnt <= '0;
        if (mismatch) begin
          if (err_count != '1) err_count <= err_count + 1'b1;
          if (!first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_idx   <= rx_count;
            first_err_data  <= data_in;
          end
        end
      end else if (r_empty) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

  assign busy    = (state == RUN);
  assign done    = (state == DONE);
  assign pass    = done && (err_count == '0);
  assign timeout = (state == TMO);

endmodule

// File: tb/tb_fifo_stream_checker.sv
// Bench for fifo_stream_checker: a queue-based FIFO model feeds the DUT, a
// scoreboard of expected per-word outcomes is checked by an independent monitor.
module tb_fifo_stream_checker;

  logic        read_clk;
  logic        reset;
  logic        enable;
  logic        r_empty;
  logic [15:0] data_in;
  logic        rd_en;
  logic [15:0] rx_count, err_count, first_err_idx, first_err_data;
  logic        first_err_valid, busy, done, pass, timeout;

  logic        w_enable, w_empty, w_rd_en;
  logic [15:0] w_data, w_rx_count, w_err_count, w_fidx, w_fdata;
  logic        w_fev, w_busy, w_done, w_pass, w_timeout;

  fifo_stream_checker #(.W(16), .STEP(5), .COUNT(256), .CW(16), .TIMEOUT(8)) u_dut (
    .read_clk(read_clk), .reset(reset), .enable(enable), .r_empty(r_empty),
    .data_in(data_in), .rd_en(rd_en), .rx_count(rx_count), .err_count(err_count),
    .first_err_valid(first_err_valid), .first_err_idx(first_err_idx),
    .first_err_data(first_err_data), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout)
  );

  fifo_stream_checker #(.W(16), .STEP(300), .COUNT(300), .CW(16), .TIMEOUT(8)) u_wrap (
    .read_clk(read_clk), .reset(reset), .enable(w_enable), .r_empty(w_empty),
    .data_in(w_data), .rd_en(w_rd_en), .rx_count(w_rx_count), .err_count(w_err_count),
    .first_err_valid(w_fev), .first_err_idx(w_fidx), .first_err_data(w_fdata),
    .busy(w_busy), .done(w_done), .pass(w_pass), .timeout(w_timeout)
  );

  typedef struct {
    int unsigned idx;
    logic [15:0] word;
    bit          err;
  } ent_t;

  ent_t        sb[$];
  logic [15:0] fifo_q[$];
  logic [15:0] wq[$];
  bit          bubbles;
  int unsigned checks, errors;
  int unsigned push_n, exp_errs, exp_first;
  logic [15:0] exp_first_data;

  initial read_clk = 1'b0;
  always #5 read_clk = ~read_clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_word(int unsigned n, int unsigned step);
    return 16'((longint'(n) * longint'(step)) % 65536);
  endfunction

  function automatic void new_run();
    push_n = 0; exp_errs = 0; exp_first = 0; exp_first_data = '0;
    fifo_q.delete(); sb.delete();
  endfunction

  function automatic void push(logic [15:0] w);
    ent_t e;
    e.idx = push_n; e.word = w; e.err = (w != ref_word(push_n, 5));
    if (e.err && exp_errs == 0) begin exp_first = push_n; exp_first_data = w; end
    if (e.err) exp_errs++;
    fifo_q.push_back(w);
    sb.push_back(e);
    push_n++;
  endfunction

  // Show-ahead FIFO model for the main DUT, with short random empty bubbles.
  initial begin
    int unsigned burst;
    bit do_pop;
    burst = 0; r_empty = 1'b1; data_in = '0;
    forever begin
      @(negedge read_clk);
      if (fifo_q.size() != 0 && !(bubbles && burst < 3 && $urandom_range(0, 3) == 0)) begin
        r_empty = 1'b0; data_in = fifo_q[0]; burst = 0;
      end else begin
        r_empty = 1'b1; data_in = 16'($urandom);
        if (fifo_q.size() != 0) burst++;
      end
      #2 do_pop = rd_en;
      @(posedge read_clk);
      if (do_pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
    end
  end

  initial begin
    int unsigned burst;
    bit do_pop;
    burst = 0; w_empty = 1'b1; w_data = '0;
    forever begin
      @(negedge read_clk);
      if (wq.size() != 0 && !(burst < 3 && $urandom_range(0, 3) == 0)) begin
        w_empty = 1'b0; w_data = wq[0]; burst = 0;
      end else begin
        w_empty = 1'b1; w_data = 16'($urandom);
        if (wq.size() != 0) burst++;
      end
      #2 do_pop = w_rd_en;
      @(posedge read_clk);
      if (do_pop && wq.size() != 0) void'(wq.pop_front());
    end
  end

  // Monitor: every pop consumes one scoreboard entry and checks the counters.
  initial begin
    bit popped;
    int unsigned m_err, m_fidx;
    logic [15:0] m_fdata;
    ent_t e;
    m_err = 0; m_fidx = 0; m_fdata = '0;
    forever begin
      @(negedge read_clk); #3;
      popped = rd_en;
      @(posedge read_clk); #1;
      if (popped) begin
        chk("pop_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          if (e.idx == 0) m_err = 0;
          if (e.err) begin
            if (m_err == 0) begin m_fidx = e.idx; m_fdata = e.word; end
            m_err++;
          end
          chk("pop_rx_count", rx_count, e.idx + 1);
          chk("pop_err_count", err_count, m_err);
          chk("pop_first_valid", first_err_valid, m_err != 0);
          if (m_err != 0) begin
            chk("pop_first_idx", first_err_idx, m_fidx);
            chk("pop_first_data", first_err_data, m_fdata);
          end
          chk("pop_done", done, e.idx + 1 == 256);
        end
      end
    end
  end

  task automatic wait_end(int unsigned budget);
    int unsigned n;
    n = 0;
    @(posedge read_clk); #1;
    while (!(done || timeout) && n < budget) begin @(posedge read_clk); #1; n++; end
    chk("run_ended", done || timeout, 1);
  endtask

  task automatic wait_rx(int unsigned target, int unsigned budget);
    int unsigned n;
    n = 0;
    @(posedge read_clk); #1;
    while (rx_count != 16'(target) && n < budget) begin @(posedge read_clk); #1; n++; end
    chk("rx_reached", rx_count, target);
  endtask

  task automatic check_end(string tag);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_pass"}, pass, exp_errs == 0);
    chk({tag, "_rx_count"}, rx_count, 256);
    chk({tag, "_err_count"}, err_count, exp_errs);
    chk({tag, "_first_valid"}, first_err_valid, exp_errs != 0);
    if (exp_errs != 0) begin
      chk({tag, "_first_idx"}, first_err_idx, exp_first);
      chk({tag, "_first_data"}, first_err_data, exp_first_data);
    end
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, "_flags"}, {busy, done, pass, timeout, first_err_valid}, 0);
    chk({tag, "_counts"}, {rx_count, err_count}, 0);
    chk({tag, "_capture"}, {first_err_idx, first_err_data}, 0);
  endtask

  initial begin
    int unsigned n;
    logic [15:0] w;
    checks = 0; errors = 0; bubbles = 0;
    reset = 1'b0; enable = 1'b1; w_enable = 1'b0;
    new_run();
    for (int i = 0; i < 4; i++) fifo_q.push_back(16'(i));

    for (int i = 0; i < 3; i++) begin
      @(negedge read_clk); #2;
      chk("reset_rd_en", rd_en, 0);
      @(posedge read_clk); #1;
      check_all_zero("reset");
    end

    @(negedge read_clk);
    reset = 1'b1; enable = 1'b0; new_run(); bubbles = 1;
    @(negedge read_clk);
    for (int i = 0; i < 256; i++)
      push(i == 7 ? 16'hFFFF : (i == 9 ? 16'h0000 : ref_word(i, 5)));
    enable = 1'b1;
    wait_end(3000);
    check_end("corrupt");

    for (int i = 0; i < 4; i++) fifo_q.push_back(ref_word(256 + i, 5));
    repeat (5) begin @(posedge read_clk); #1; end
    chk("done_hold_rx", rx_count, 256);
    chk("done_hold_done", done, 1);

    @(negedge read_clk);
    enable = 1'b0; new_run();
    @(posedge read_clk); #1;
    chk("idle_busy_done", {busy, done}, 0);
    chk("idle_keep_rx", rx_count, 256);
    chk("idle_keep_err", err_count, 2);
    chk("idle_keep_first", {first_err_valid, first_err_idx}, {1'b1, 16'd7});

    @(negedge read_clk);
    for (int i = 0; i < 256; i++) push(ref_word(i, 5));
    enable = 1'b1;
    @(posedge read_clk); #1;
    chk("restart_busy", busy, 1);
    chk("restart_counts", {rx_count, err_count}, 0);
    chk("restart_first_valid", first_err_valid, 0);
    wait_end(3000);
    check_end("clean");

    @(negedge read_clk);
    enable = 1'b0; new_run();
    @(negedge read_clk);
    for (int i = 0; i < 256; i++) begin
      w = ref_word(i, 5);
      if ($urandom_range(0, 5) == 0) w = 16'($urandom);
      push(w);
    end
    enable = 1'b1;
    wait_end(3000);
    check_end("random");

    @(negedge read_clk);
    enable = 1'b0; new_run(); bubbles = 0;
    @(negedge read_clk);
    for (int i = 0; i < 3; i++) push(ref_word(i, 5));
    enable = 1'b1;
    wait_rx(3, 50);
    for (int k = 1; k <= 8; k++) begin
      @(posedge read_clk); #1;
      chk("tmo_flag", timeout, k == 8);
      chk("tmo_busy", busy, k < 8);
    end
    @(negedge read_clk); #2;
    chk("tmo_rd_en", rd_en, 0);
    chk("tmo_rx_count", rx_count, 3);
    chk("tmo_done", done, 0);

    @(negedge read_clk);
    enable = 1'b0; new_run(); bubbles = 1;
    @(negedge read_clk);
    for (int i = 0; i < 20; i++) push(ref_word(i, 5));
    enable = 1'b1;
    wait_rx(10, 200);
    @(negedge read_clk);
    reset = 1'b0; sb.delete();
    #2 chk("abort_rd_en", rd_en, 0);
    @(posedge read_clk); #1;
    check_all_zero("abort");
    @(negedge read_clk);
    reset = 1'b1; enable = 1'b0; fifo_q.delete();

    @(negedge read_clk);
    for (int i = 0; i < 300; i++) wq.push_back(ref_word(i, 300));
    w_enable = 1'b1;
    n = 0;
    @(posedge read_clk); #1;
    while (!(w_done || w_timeout) && n < 3000) begin @(posedge read_clk); #1; n++; end
    chk("wrap_done", w_done, 1);
    chk("wrap_pass", w_pass, 1);
    chk("wrap_rx_count", w_rx_count, 300);
    chk("wrap_err_count", w_err_count, 0);
    chk("wrap_first_valid", w_fev, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
